// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_seq
// Purpose  : Memory access sequencer for a multicycle datapath. Arbitrates
//            instruction-fetch and data (load/store) requests, drives the
//            IorD address mux select, and produces the memory write strobe
//            and IR/MDR capture strobes timed to the memory latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_seq #(
    parameter int MEM_LAT = 1,   // memory wait cycles between address phase and capture (0..15)
    parameter int CNT_W   = 4    // width of the wait counter; must hold MEM_LAT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_we,
    input  logic [1:0] alu_lo,
    output logic       iord_sel,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       mdr_wr,
    output logic       busy,
    output logic       fetch_done,
    output logic       data_done,
    output logic       data_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Grant encoding used for the round-robin history bit.
    localparam logic c_grant_fetch = 1'b0;

    // Counter preload; clamped so a zero-latency build still gets a legal value.
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);

    // A zero-latency memory goes straight from the address phase to capture.
    localparam logic c_skip_wait = (MEM_LAT == 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;   // 0 = fetch served last, 1 = data served last
    logic             r_gnt_data;     // current access is a data access
    logic             r_gnt_store;    // current data access is a store

    logic             r_iord_sel;
    logic             r_mem_wr;
    logic             r_ir_wr;
    logic             r_mdr_wr;
    logic             r_busy;
    logic             r_fetch_done;
    logic             r_data_done;
    logic             r_data_err;

    logic             w_grant_valid;
    logic             w_grant_data;
    logic             w_misaligned;
    logic             w_cap_ir;
    logic             w_cap_mdr;
    logic             w_cap_fetch_done;
    logic             w_cap_data_done;

    // Arbitration: a lone request wins; when both are pending the side not served last wins.
    always_comb begin
        w_grant_valid = fetch_req | data_req;
        if (fetch_req && data_req) begin
            w_grant_data = (r_last_grant == c_grant_fetch);
        end else begin
            w_grant_data = data_req;
        end
        w_misaligned = w_grant_data && (alu_lo != 2'b00);
    end

    // Strobes presented during CAPTURE, derived from the latched grant type.
    always_comb begin
        w_cap_ir         = ~r_gnt_data;
        w_cap_mdr        = r_gnt_data & ~r_gnt_store;
        w_cap_fetch_done = ~r_gnt_data;
        w_cap_data_done  = r_gnt_data;
    end

    // Sequencer FSM; every output is registered so none depends combinationally on inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= c_grant_fetch;
            r_gnt_data   <= 1'b0;
            r_gnt_store  <= 1'b0;
            r_iord_sel   <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_ir_wr      <= 1'b0;
            r_mdr_wr     <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_data_err   <= 1'b0;
        end else begin
            // Single-cycle strobes default low and are raised only on the relevant transition.
            r_mem_wr     <= 1'b0;
            r_ir_wr      <= 1'b0;
            r_mdr_wr     <= 1'b0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_data_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        if (w_misaligned) begin
                            // Reject without touching memory; history is left as-is.
                            r_data_err <= 1'b1;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_gnt_data  <= w_grant_data;
                            r_gnt_store <= w_grant_data & data_we;
                            r_iord_sel  <= w_grant_data;
                            r_mem_wr    <= w_grant_data & data_we;
                            r_busy      <= 1'b1;
                            r_cnt       <= c_cnt_load;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (c_skip_wait) begin
                        r_state      <= ST_CAPTURE;
                        r_ir_wr      <= w_cap_ir;
                        r_mdr_wr     <= w_cap_mdr;
                        r_fetch_done <= w_cap_fetch_done;
                        r_data_done  <= w_cap_data_done;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= ST_CAPTURE;
                        r_ir_wr      <= w_cap_ir;
                        r_mdr_wr     <= w_cap_mdr;
                        r_fetch_done <= w_cap_fetch_done;
                        r_data_done  <= w_cap_data_done;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    // Always pass through IDLE so a held request is re-sampled one cycle later.
                    r_state      <= ST_IDLE;
                    r_iord_sel   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_last_grant <= r_gnt_data;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_iord_sel <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign iord_sel   = r_iord_sel;
    assign mem_wr     = r_mem_wr;
    assign ir_wr      = r_ir_wr;
    assign mdr_wr     = r_mdr_wr;
    assign busy       = r_busy;
    assign fetch_done = r_fetch_done;
    assign data_done  = r_data_done;
    assign data_err   = r_data_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_seq
// Purpose  : Directed self-checking bench for mem_access_seq, covering a
//            MEM_LAT=1 instance and a MEM_LAT=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_seq;

    logic       clk;
    logic       reset_n;

    // Stimulus and observation for the MEM_LAT=1 instance.
    logic       fr1, dr1, we1;
    logic [1:0] alo1;
    logic       iord1, memwr1, irwr1, mdrwr1, busy1, fdone1, ddone1, derr1;

    // Stimulus and observation for the MEM_LAT=0 instance.
    logic       fr0, dr0, we0;
    logic [1:0] alo0;
    logic       iord0, memwr0, irwr0, mdrwr0, busy0, fdone0, ddone0, derr0;

    int n_cmp;
    int n_err;

    mem_access_seq #(.MEM_LAT(1), .CNT_W(4)) u_lat1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fr1),
        .data_req   (dr1),
        .data_we    (we1),
        .alu_lo     (alo1),
        .iord_sel   (iord1),
        .mem_wr     (memwr1),
        .ir_wr      (irwr1),
        .mdr_wr     (mdrwr1),
        .busy       (busy1),
        .fetch_done (fdone1),
        .data_done  (ddone1),
        .data_err   (derr1)
    );

    mem_access_seq #(.MEM_LAT(0), .CNT_W(4)) u_lat0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fr0),
        .data_req   (dr0),
        .data_we    (we0),
        .alu_lo     (alo0),
        .iord_sel   (iord0),
        .mem_wr     (memwr0),
        .ir_wr      (irwr0),
        .mdr_wr     (mdrwr0),
        .busy       (busy0),
        .fetch_done (fdone0),
        .data_done  (ddone0),
        .data_err   (derr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every output of the MEM_LAT=1 instance in one go.
    task automatic chk1(input string tag,
                        input logic e_iord, input logic e_memwr, input logic e_irwr,
                        input logic e_mdrwr, input logic e_busy, input logic e_fdone,
                        input logic e_ddone, input logic e_derr);
        chk({tag, ".iord_sel"},   iord1,  e_iord);
        chk({tag, ".mem_wr"},     memwr1, e_memwr);
        chk({tag, ".ir_wr"},      irwr1,  e_irwr);
        chk({tag, ".mdr_wr"},     mdrwr1, e_mdrwr);
        chk({tag, ".busy"},       busy1,  e_busy);
        chk({tag, ".fetch_done"}, fdone1, e_fdone);
        chk({tag, ".data_done"},  ddone1, e_ddone);
        chk({tag, ".data_err"},   derr1,  e_derr);
    endtask

    // Check every output of the MEM_LAT=0 instance in one go.
    task automatic chk0(input string tag,
                        input logic e_iord, input logic e_memwr, input logic e_irwr,
                        input logic e_mdrwr, input logic e_busy, input logic e_fdone,
                        input logic e_ddone, input logic e_derr);
        chk({tag, ".iord_sel"},   iord0,  e_iord);
        chk({tag, ".mem_wr"},     memwr0, e_memwr);
        chk({tag, ".ir_wr"},      irwr0,  e_irwr);
        chk({tag, ".mdr_wr"},     mdrwr0, e_mdrwr);
        chk({tag, ".busy"},       busy0,  e_busy);
        chk({tag, ".fetch_done"}, fdone0, e_fdone);
        chk({tag, ".data_done"},  ddone0, e_ddone);
        chk({tag, ".data_err"},   derr0,  e_derr);
    endtask

    // Hold reset across one edge, then release it away from the edge.
    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        fr1 = 1'b0; dr1 = 1'b0; we1 = 1'b0; alo1 = 2'b00;
        fr0 = 1'b0; dr0 = 1'b0; we0 = 1'b0; alo0 = 2'b00;

        // Reset state.
        #2;
        chk1("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
        chk0("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk1("idle1", 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch, MEM_LAT=1: ACCESS c1, WAIT c2, CAPTURE c3.
        fr1 = 1'b1;
        tick(); chk1("fetch.c1", 0, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("fetch.c2", 0, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("fetch.c3", 0, 0, 1, 0, 1, 1, 0, 0);
        fr1 = 1'b0;
        tick(); chk1("fetch.c4", 0, 0, 0, 0, 0, 0, 0, 0);

        // Aligned store; data_we/alu_lo changed while busy must have no effect.
        dr1 = 1'b1; we1 = 1'b1; alo1 = 2'b00;
        tick(); chk1("store.c1", 1, 1, 0, 0, 1, 0, 0, 0);
        we1 = 1'b0; alo1 = 2'b11;
        tick(); chk1("store.c2", 1, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("store.c3", 1, 0, 0, 0, 1, 0, 1, 0);
        dr1 = 1'b0;
        tick(); chk1("store.c4", 0, 0, 0, 0, 0, 0, 0, 0);

        // Misaligned load: error pulse only, no access.
        dr1 = 1'b1; we1 = 1'b0; alo1 = 2'b10;
        tick(); chk1("misal.c1", 0, 0, 0, 0, 0, 0, 0, 1);
        dr1 = 1'b0;
        tick(); chk1("misal.c2", 0, 0, 0, 0, 0, 0, 0, 0);

        // Aligned load, MEM_LAT=1: mdr_wr with data_done in c3.
        dr1 = 1'b1; we1 = 1'b0; alo1 = 2'b00;
        tick(); chk1("load.c1", 1, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("load.c2", 1, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("load.c3", 1, 0, 0, 1, 1, 0, 1, 0);
        dr1 = 1'b0;
        tick(); chk1("load.c4", 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during the ACCESS cycle of a store: mem_wr drops before any clock edge.
        dr1 = 1'b1; we1 = 1'b1; alo1 = 2'b00;
        tick(); chk1("rstacc.c1", 1, 1, 0, 0, 1, 0, 0, 0);
        dr1 = 1'b0; we1 = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk1("rstacc.async", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;

        // Reset mid-WAIT of a store, then a normal fetch.
        dr1 = 1'b1; we1 = 1'b1; alo1 = 2'b00;
        tick(); chk1("rstwait.c1", 1, 1, 0, 0, 1, 0, 0, 0);
        tick(); chk1("rstwait.c2", 1, 0, 0, 0, 1, 0, 0, 0);
        dr1 = 1'b0; we1 = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk1("rstwait.async", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        tick(); chk1("rstwait.idle", 0, 0, 0, 0, 0, 0, 0, 0);
        fr1 = 1'b1;
        tick(); chk1("postrst.c1", 0, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("postrst.c2", 0, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk1("postrst.c3", 0, 0, 1, 0, 1, 1, 0, 0);
        fr1 = 1'b0;
        tick(); chk1("postrst.c4", 0, 0, 0, 0, 0, 0, 0, 0);

        // Both requests held from reset: data, fetch, data, fetch (loads).
        do_reset();
        fr1 = 1'b1; dr1 = 1'b1; we1 = 1'b0; alo1 = 2'b00;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            tick(); chk1($sformatf("rr%0d.access", k), exp_d, 0, 0, 0, 1, 0, 0, 0);
            tick(); chk1($sformatf("rr%0d.wait", k), exp_d, 0, 0, 0, 1, 0, 0, 0);
            tick(); chk1($sformatf("rr%0d.capture", k), exp_d, 0, !exp_d, exp_d, 1, !exp_d, exp_d, 0);
            tick(); chk1($sformatf("rr%0d.idle", k), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        fr1 = 1'b0; dr1 = 1'b0;
        tick(); chk1("rr.end", 0, 0, 0, 0, 0, 0, 0, 0);

        // MEM_LAT=0 load: ACCESS c1, CAPTURE c2, no WAIT.
        dr0 = 1'b1; we0 = 1'b0; alo0 = 2'b00;
        tick(); chk0("lat0.c1", 1, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk0("lat0.c2", 1, 0, 0, 1, 1, 0, 1, 0);
        dr0 = 1'b0;
        tick(); chk0("lat0.c3", 0, 0, 0, 0, 0, 0, 0, 0);

        // MEM_LAT=0 fetch.
        fr0 = 1'b1;
        tick(); chk0("lat0f.c1", 0, 0, 0, 0, 1, 0, 0, 0);
        tick(); chk0("lat0f.c2", 0, 0, 1, 0, 1, 1, 0, 0);
        fr0 = 1'b0;
        tick(); chk0("lat0f.c3", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
